// File: rtl/fp_exec_unit.sv
// Multi-cycle single-precision FADD/FMUL unit: IDLE -> EXEC -> NORM -> PACK -> DONE.
// Denormals flush to zero, rounding truncates, NaN results are canonical.
module fp_exec_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           ALUControl,
    input  logic [EXP_W+MAN_W:0] SrcA,
    input  logic [EXP_W+MAN_W:0] SrcB,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] Result,
    output logic [3:0]           ALUFlags,
    output logic                 invalid
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int M   = MAN_W + 1;
    localparam int MW  = 2 * M;
    localparam int EW  = EXP_W + 2;
    localparam int GW  = M + 3;
    localparam int LZW = $clog2(MW);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, EXEC, NORM, PACK, DONE} state_t;
    state_t state;

    logic [2:0]       op_r;
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [M-1:0]     ma, mb;
    logic [MW-1:0]    mag_r;
    logic [EW-1:0]    exp_r;
    logic             sgn_r, nan_r, inf_r, zero_r;

    logic             is_add, is_mul, a_big;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             sl, ss;
    logic [EXP_W-1:0] el, es, diff;
    logic [M-1:0]     ml, msm;
    logic [2*GW-1:0]  sh;
    logic [GW-1:0]    small_al;
    logic [GW:0]      sum;
    logic [MW-1:0]    prod, x_mag;
    logic [EW-1:0]    x_exp;
    logic             x_sign, x_nan, x_inf;

    always_comb begin
        is_add = (op_r == 3'b100);
        is_mul = (op_r == 3'b101);
        a_nan  = (ea == EMAX) && (|ma[MAN_W-1:0]);
        b_nan  = (eb == EMAX) && (|mb[MAN_W-1:0]);
        a_inf  = (ea == EMAX) && !(|ma[MAN_W-1:0]);
        b_inf  = (eb == EMAX) && !(|mb[MAN_W-1:0]);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_big  = {ea, ma} >= {eb, mb};
        sl     = a_big ? sa : sb;
        ss     = a_big ? sb : sa;
        el     = a_big ? ea : eb;
        es     = a_big ? eb : ea;
        ml     = a_big ? ma : mb;
        msm    = a_big ? mb : ma;
        diff   = el - es;
        // Bits shifted below the guard/round pair collapse into the sticky LSB.
        sh       = {msm, 3'b000, {GW{1'b0}}} >> diff;
        small_al = (diff >= EXP_W'(GW - 1)) ? '0 : {sh[2*GW-1:GW+1], sh[GW] | (|sh[GW-1:0])};
        sum      = (sl == ss) ? {1'b0, ml, 3'b000} + {1'b0, small_al}
                              : {1'b0, ml, 3'b000} - {1'b0, small_al};
        prod     = MW'(ma) * MW'(mb);
        // Both paths share one layout: carry at MW-1, leading one at MW-2.
        x_mag  = is_add ? {sum, {(MW-GW-1){1'b0}}} : prod;
        x_exp  = is_add ? EW'(el) : EW'(ea) + EW'(eb) - EW'(BIAS);
        x_inf  = a_inf || b_inf;
        x_sign = is_mul ? (sa ^ sb) : (x_inf ? (a_inf ? sa : sb) : sl);
        x_nan  = !(is_add || is_mul) || a_nan || b_nan
              || (is_add && a_inf && b_inf && (sa != sb))
              || (is_mul && ((a_inf && b_zero) || (b_inf && a_zero)));
    end

    logic [LZW-1:0] lz;
    logic [MW-1:0]  mag_n;
    logic [EW-1:0]  exp_n;

    always_comb begin
        lz = LZW'(MW - 1);
        for (int i = 0; i < MW - 1; i++)
            if (mag_r[i]) lz = LZW'(MW - 2 - i);
        if (mag_r[MW-1]) begin
            mag_n = mag_r >> 1;
            exp_n = exp_r + EW'(1);
        end else begin
            mag_n = mag_r << lz;
            exp_n = exp_r - EW'(lz);
        end
    end

    logic [W-1:0] res_c;
    logic [3:0]   flags_c;

    always_comb begin
        if (nan_r)
            res_c = QNAN;
        else if (inf_r)
            res_c = {sgn_r, EMAX, {MAN_W{1'b0}}};
        else if (zero_r)
            res_c = '0;
        else if (!exp_r[EW-1] && (exp_r >= EW'(EMAX)))
            res_c = {sgn_r, EMAX, {MAN_W{1'b0}}};
        else if (exp_r[EW-1] || (exp_r == '0))
            res_c = {sgn_r, {(W-1){1'b0}}};
        else
            res_c = {sgn_r, exp_r[EXP_W-1:0], mag_r[MW-3 -: MAN_W]};
        flags_c = nan_r ? 4'b0000 : {res_c[W-1], ~(|res_c[W-2:0]), 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            Result   <= '0;
            ALUFlags <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    invalid <= 1'b0;
                    if (start) begin
                        op_r  <= ALUControl;
                        sa    <= SrcA[W-1];
                        sb    <= SrcB[W-1];
                        ea    <= SrcA[W-2 -: EXP_W];
                        eb    <= SrcB[W-2 -: EXP_W];
                        ma    <= (|SrcA[W-2 -: EXP_W]) ? {1'b1, SrcA[MAN_W-1:0]} : '0;
                        mb    <= (|SrcB[W-2 -: EXP_W]) ? {1'b1, SrcB[MAN_W-1:0]} : '0;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    mag_r <= x_mag;
                    exp_r <= x_exp;
                    sgn_r <= x_sign;
                    nan_r <= x_nan;
                    inf_r <= x_inf && !x_nan;
                    state <= NORM;
                end
                NORM: begin
                    mag_r  <= mag_n;
                    exp_r  <= exp_n;
                    zero_r <= (mag_r == '0);
                    state  <= PACK;
                end
                PACK: begin
                    Result   <= res_c;
                    ALUFlags <= flags_c;
                    invalid  <= nan_r;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    invalid <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
